tlb_miss_walker: RTL and testbench
==================================

# tlb_miss_walker

Hardware page-table walker that services TLB misses and produces the refill that installs new translations in `tlb_cache`. It collects at most one outstanding miss per hardware thread, arbitrates round-robin between threads, and fetches the page-table entry (PTE) through a single-outstanding memory port. It then either pulses a TLB refill or reports a page fault to the owning thread. It sits between the fetch/memory-stage TLB miss outputs and the `new_tlb_entry` / `new_tlb_thread_id` / `new_tlb_info` inputs of `tlb_cache`.

## Interface
Parameters:
- THREADS, 4, hardware threads per core; power of 2, ≥2.
- TID_W, 2, log2(THREADS); matches `THR_PER_CORE_WIDTH`.
- VADDR_W, 32, virtual address width.
- PADDR_W, 20, physical address width.
- OFFSET_W, 12, page offset width (4 KiB pages).
- PTE_W, 32, PTE width; must be ≥ PADDR_W.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ptbr  in  PADDR_W  page-table base; sampled in SEND.
- flush  in  1  abort all pending walks.
- miss_valid  in  1  TLB miss report.
- miss_thread_id  in  TID_W  thread that missed.
- miss_virt_addr  in  VADDR_W  faulting virtual address.
- pending  out  THREADS  per-thread walk-outstanding vector (stall hint).
- mem_req_valid  out  1  PTE read request.
- mem_req_addr  out  PADDR_W  PTE address.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  PTE data returned.
- mem_rsp_data  in  PTE_W  PTE.
- new_tlb_entry  out  1  refill pulse to `tlb_cache`.
- new_tlb_thread_id  out  TID_W  refill owner.
- new_tlb_info  out  tlb_req_info_t  `{virt_addr, phy_addr}` of the refill.
- page_fault  out  1  invalid-PTE pulse.
- page_fault_thread_id  out  TID_W  faulting thread.
- page_fault_addr  out  VADDR_W  faulting virtual address.

## Operation
- **Miss capture.** Per thread, keep a `pending` bit and a stored VA.
  - On `miss_valid`, if `pending[tid]`=0: set the bit and store the VA.
  - If `pending[tid]`=1: ignore the miss (duplicate retry).
  - If set and clear of the same thread's bit coincide, set wins and the new VA is stored.
- **FSM states:** IDLE, SEND, WAIT, FILL, DRAIN.
  - **IDLE.** If any pending bit is set, select a thread round-robin: start at `last_served+1` modulo THREADS and pick the first pending thread. Latch its id and VA, then go to SEND.
  - **SEND.** `mem_req_valid`=1 and `mem_req_addr` = `ptbr + (VA[VADDR_W-1:OFFSET_W] << 2)`, truncated modulo 2^PADDR_W. The address is held stable until `mem_req_ready`, then go to WAIT.
  - **WAIT.** On `mem_rsp_valid`, capture the PTE and go to FILL.
  - **FILL (one cycle).**
    - If `PTE[0]`=1: `new_tlb_entry`=1; `new_tlb_info.phy_addr` = `{PTE[PADDR_W-1:OFFSET_W], VA[OFFSET_W-1:0]}`; `virt_addr` = VA.
    - Otherwise: `page_fault`=1 with the thread id and VA.
    - In both cases, clear `pending[tid]`, update `last_served`=tid, and go to IDLE.
- **Flush.** `flush` clears all pending bits the same edge.
  - IDLE or SEND: go to IDLE. Dropping `mem_req_valid` is legal only because no handshake has completed.
  - WAIT: go to DRAIN. DRAIN consumes one `mem_rsp_valid`, produces no output, then goes to IDLE.
  - FILL: the FILL output is suppressed.
  - Misses arriving in the same cycle as `flush` are dropped.
- Only one walk is outstanding at any time. The memory port is never re-issued before its response.

## Timing
- Reset values: `pending`=0, `last_served`=THREADS-1 (so thread 0 wins first), state IDLE. All outputs are 0: `mem_req_valid`, `new_tlb_entry`, `page_fault`, ids, addresses, `new_tlb_info`.
- Reset mid-walk returns to IDLE immediately. The memory side shares the same reset, so no response is expected afterwards.
- Minimum miss-to-refill latency, for a miss at cycle T:
  - `pending` visible at T+1;
  - SEND (`mem_req_valid`) at T+2;
  - WAIT at T+3 if ready at T+2;
  - response at T+3 gives FILL (`new_tlb_entry`) at T+4.
- `new_tlb_entry` and `page_fault` are exactly 1-cycle pulses, registered outputs, and never asserted together.
- After FILL, the next walk can issue `mem_req_valid` 2 cycles later (IDLE, then SEND).

## Test plan
- Basic refill: THREADS=4, PADDR_W=20, `ptbr`=0x10000, thread 1 misses VA 0x00003ABC. Required: `mem_req_addr`=0x1000C at T+2. With PTE=0x00045001 returned, at T+4 `new_tlb_entry`=1, thread 1, `phy_addr`=0x45ABC, `virt_addr`=0x00003ABC.
- Page fault: same as basic refill but PTE=0x00045000. Required: `page_fault`=1, thread 1, addr 0x00003ABC; `new_tlb_entry` stays 0; `pending[1]` cleared.
- Round-robin: threads 0, 2, 3 miss in one cycle, and thread 0 misses again after its FILL. Required service order 0, 2, 3, 0. `mem_req_ready` held low 5 cycles in SEND keeps `mem_req_addr` stable.
- Duplicate/coincident misses:
  - Thread 2 misses VA A, then VA B while pending. Required: B is ignored and the refill carries A.
  - A thread-2 miss in its own FILL cycle. Required: `pending[2]`=1 afterwards with the new VA.
- Flush in WAIT: assert `flush` one cycle after the handshake, with a response 3 cycles later. Required: no refill or fault pulse, `pending`=0, next `mem_req_valid` only after a new miss.
- Reset in WAIT: pulse `reset`. Required: all outputs 0 and `pending`=0 on the next cycle, and the first post-reset miss walks normally.

Source files
------------

// File: rtl/tlb_miss_walker.sv
// Page-table walker for TLB misses. It keeps one outstanding miss per
// hardware thread and picks the next walk round-robin. Each walk reads one
// PTE over a single-outstanding memory port. The walk ends with either a
// one-cycle refill pulse towards tlb_cache or a one-cycle page-fault pulse.
//
// new_tlb_info is packed as {virt_addr, phy_addr}: virt_addr occupies the
// upper VADDR_W bits and phy_addr the lower PADDR_W bits.
module tlb_miss_walker #(
  parameter int THREADS  = 4,
  parameter int TID_W    = 2,
  parameter int VADDR_W  = 32,
  parameter int PADDR_W  = 20,
  parameter int OFFSET_W = 12,
  parameter int PTE_W    = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PADDR_W-1:0]         ptbr,
  input  logic                       flush,
  input  logic                       miss_valid,
  input  logic [TID_W-1:0]           miss_thread_id,
  input  logic [VADDR_W-1:0]         miss_virt_addr,
  output logic [THREADS-1:0]         pending,
  output logic                       mem_req_valid,
  output logic [PADDR_W-1:0]         mem_req_addr,
  input  logic                       mem_req_ready,
  input  logic                       mem_rsp_valid,
  input  logic [PTE_W-1:0]           mem_rsp_data,
  output logic                       new_tlb_entry,
  output logic [TID_W-1:0]           new_tlb_thread_id,
  output logic [VADDR_W+PADDR_W-1:0] new_tlb_info,
  output logic                       page_fault,
  output logic [TID_W-1:0]           page_fault_thread_id,
  output logic [VADDR_W-1:0]         page_fault_addr
);

  localparam int VPN_W = VADDR_W - OFFSET_W;
  localparam int PPN_W = PADDR_W - OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_FILL,
    S_DRAIN
  } state_t;

  // PTE address: table base plus 4 bytes per virtual page number, wrapping
  // modulo 2^PADDR_W.
  function automatic logic [PADDR_W-1:0] pte_addr(
    input logic [PADDR_W-1:0] base,
    input logic [VPN_W-1:0]   vpn
  );
    logic [VPN_W+1:0] vpn_x4;
    vpn_x4 = {vpn, 2'b00};
    return base + PADDR_W'(vpn_x4);
  endfunction

  // Physical address: frame number from the PTE, offset from the VA.
  function automatic logic [PADDR_W-1:0] phys_addr(
    input logic [PPN_W-1:0]    ppn,
    input logic [OFFSET_W-1:0] offset
  );
    return {ppn, offset};
  endfunction

  // Round-robin pick. It starts one past the last served thread and wraps.
  // The result is {found, tid}. The downward loop lets the nearest
  // candidate win, and the offset THREADS (the last served thread itself)
  // has the lowest priority.
  function automatic logic [TID_W:0] rr_pick(
    input logic [THREADS-1:0] req,
    input logic [TID_W-1:0]   last
  );
    logic [TID_W-1:0] idx;
    logic [TID_W:0]   res;
    res = '0;
    for (int i = THREADS; i >= 1; i--) begin
      idx = last + TID_W'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  state_t               state_q, state_d;
  logic [THREADS-1:0]   pending_q, pending_d;
  logic [THREADS-1:0]   clr;
  logic                 miss_take;
  logic [VADDR_W-1:0]   va_q [THREADS];
  logic [TID_W-1:0]     last_q, last_d;
  logic [TID_W-1:0]     cur_tid_q, cur_tid_d;
  logic [VADDR_W-1:0]   cur_va_q, cur_va_d;
  logic [TID_W:0]       pick;
  logic                 ent_q, ent_d;
  logic                 flt_q, flt_d;
  logic [TID_W-1:0]     out_tid_q, out_tid_d;
  logic [VADDR_W-1:0]   out_va_q, out_va_d;
  logic [PADDR_W-1:0]   out_pa_q, out_pa_d;

  // Only PTE[0] and the frame-number field carry meaning for the walker.
  logic unused_pte_bits;
  assign unused_pte_bits = ^mem_rsp_data;

  // Walk sequencing. The FILL outcome is registered on the WAIT->FILL edge,
  // so the pulses leave the block from flops.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cur_tid_d = cur_tid_q;
    cur_va_d  = cur_va_q;
    ent_d     = 1'b0;
    flt_d     = 1'b0;
    out_tid_d = '0;
    out_va_d  = '0;
    out_pa_d  = '0;
    clr       = '0;
    pick      = rr_pick(pending_q, last_q);
    unique case (state_q)
      S_IDLE: begin
        if (!flush && pick[TID_W]) begin
          state_d   = S_SEND;
          cur_tid_d = pick[TID_W-1:0];
          cur_va_d  = va_q[pick[TID_W-1:0]];
        end
      end
      S_SEND: begin
        // No handshake can have completed yet, so a flush may simply
        // withdraw the request.
        if (flush)              state_d = S_IDLE;
        else if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (flush) begin
            // The response arrives together with the flush. It is consumed
            // here and dropped, so nothing is left in flight to drain.
            state_d = S_IDLE;
          end else begin
            state_d   = S_FILL;
            ent_d     = mem_rsp_data[0];
            flt_d     = ~mem_rsp_data[0];
            out_tid_d = cur_tid_q;
            out_va_d  = cur_va_q;
            out_pa_d  = phys_addr(mem_rsp_data[PADDR_W-1:OFFSET_W],
                                  cur_va_q[OFFSET_W-1:0]);
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_FILL: begin
        state_d = S_IDLE;
        if (!flush) begin
          last_d         = cur_tid_q;
          clr[cur_tid_q] = 1'b1;
        end
      end
      S_DRAIN: begin
        if (mem_rsp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Miss capture. A miss that lands on its own thread's clearing cycle wins
  // over the clear. A flush drops both the pending bits and any new miss.
  always_comb begin
    miss_take = miss_valid && !flush &&
                (!pending_q[miss_thread_id] || clr[miss_thread_id]);
    pending_d = flush ? '0 : (pending_q & ~clr);
    if (miss_take) pending_d[miss_thread_id] = 1'b1;
  end

  // Per-thread VA storage and the in-flight walk operands (no reset needed).
  always_ff @(posedge clock) begin
    if (miss_take) va_q[miss_thread_id] <= miss_virt_addr;
    cur_tid_q <= cur_tid_d;
    cur_va_q  <= cur_va_d;
  end

  // Control state and registered FILL outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      last_q    <= TID_W'(THREADS - 1);
      ent_q     <= 1'b0;
      flt_q     <= 1'b0;
      out_tid_q <= '0;
      out_va_q  <= '0;
      out_pa_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      ent_q     <= ent_d;
      flt_q     <= flt_d;
      out_tid_q <= out_tid_d;
      out_va_q  <= out_va_d;
      out_pa_q  <= out_pa_d;
    end
  end

  assign pending       = pending_q;
  // The request is withdrawn in a flush cycle, so a flushed SEND can never
  // complete a handshake that would leave a response in flight.
  assign mem_req_valid = (state_q == S_SEND) && !flush;
  assign mem_req_addr  = mem_req_valid ?
                         pte_addr(ptbr, cur_va_q[VADDR_W-1:OFFSET_W]) : '0;

  // A flush that arrives in the FILL cycle suppresses that cycle's pulse.
  assign new_tlb_entry        = ent_q && !flush;
  assign new_tlb_thread_id    = new_tlb_entry ? out_tid_q : '0;
  assign new_tlb_info         = new_tlb_entry ? {out_va_q, out_pa_q} : '0;
  assign page_fault           = flt_q && !flush;
  assign page_fault_thread_id = page_fault ? out_tid_q : '0;
  assign page_fault_addr      = page_fault ? out_va_q : '0;

endmodule

// File: tb/tb_tlb_miss_walker.sv
// Bench for tlb_miss_walker: a transaction-level reference model, a
// per-cycle compare, directed scenarios and a randomized phase.
module tb_tlb_miss_walker;
  localparam int THREADS = 4;
  localparam int TID_W   = 2;
  localparam int VADDR_W = 32;
  localparam int PADDR_W = 20;

  logic                       clock = 1'b0;
  logic                       reset, flush, miss_valid;
  logic [TID_W-1:0]           miss_thread_id;
  logic [VADDR_W-1:0]         miss_virt_addr;
  logic [PADDR_W-1:0]         ptbr;
  logic [THREADS-1:0]         pending;
  logic                       mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [PADDR_W-1:0]         mem_req_addr;
  logic [31:0]                mem_rsp_data;
  logic                       new_tlb_entry, page_fault;
  logic [TID_W-1:0]           new_tlb_thread_id, page_fault_thread_id;
  logic [VADDR_W+PADDR_W-1:0] new_tlb_info;
  logic [VADDR_W-1:0]         page_fault_addr;

  tlb_miss_walker dut (
    .clock(clock), .reset(reset), .ptbr(ptbr), .flush(flush),
    .miss_valid(miss_valid), .miss_thread_id(miss_thread_id),
    .miss_virt_addr(miss_virt_addr), .pending(pending),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .new_tlb_entry(new_tlb_entry),
    .new_tlb_thread_id(new_tlb_thread_id), .new_tlb_info(new_tlb_info),
    .page_fault(page_fault), .page_fault_thread_id(page_fault_thread_id),
    .page_fault_addr(page_fault_addr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: the set of outstanding misses plus a record of the
  // one walk in flight.
  bit          m_pend [THREADS];
  logic [31:0] m_va   [THREADS];
  int          m_last;
  bit          w_act, w_sent, w_got, w_drain;
  int          w_tid;
  logic [31:0] w_va, w_pte;
  int          order_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit awaiting_rsp();
    return w_act && w_sent && !w_got;
  endfunction

  // Compare every output against the model for the current cycle.
  task automatic cmp();
    logic [3:0]  ep;
    bit          ev, live, ee, ef;
    logic [31:0] ea, epa;
    #1;
    for (int k = 0; k < THREADS; k++) ep[k] = m_pend[k];
    ev   = w_act && !w_sent && !flush;
    ea   = ev ? ((32'(ptbr) + (w_va >> 12) * 4) & 32'h000F_FFFF) : 32'h0;
    live = w_act && w_got && !flush;
    ee   = live && w_pte[0];
    ef   = live && !w_pte[0];
    epa  = (w_pte & 32'h000F_F000) | (w_va & 32'h0000_0FFF);
    check("pending", pending, ep);
    check("req_valid", mem_req_valid, ev);
    check("req_addr", mem_req_addr, ea);
    check("refill", new_tlb_entry, ee);
    check("refill_tid", new_tlb_thread_id, ee ? w_tid : 0);
    check("refill_info", new_tlb_info, ee ? {w_va, epa[19:0]} : 52'h0);
    check("fault", page_fault, ef);
    check("fault_tid", page_fault_thread_id, ef ? w_tid : 0);
    check("fault_addr", page_fault_addr, ef ? w_va : 32'h0);
    if (new_tlb_entry === 1'b1) order_q.push_back(int'(new_tlb_thread_id));
    else if (page_fault === 1'b1) order_q.push_back(int'(page_fault_thread_id));
  endtask

  // Advance the model by one clock edge using the inputs of this cycle.
  task automatic model_step();
    int t;
    if (reset) begin
      for (int k = 0; k < THREADS; k++) m_pend[k] = 0;
      m_last = THREADS - 1;
      w_act = 0; w_sent = 0; w_got = 0; w_drain = 0;
      return;
    end
    if (w_act && w_got) begin
      if (!flush) begin
        m_last = w_tid;
        m_pend[w_tid] = 0;
      end
      w_act = 0;
    end else if (w_act && !w_sent) begin
      if (flush) w_act = 0;
      else if (mem_req_ready) w_sent = 1;
    end else if (w_act) begin
      if (mem_rsp_valid) begin
        if (flush) w_act = 0;
        else begin
          w_got = 1;
          w_pte = mem_rsp_data;
        end
      end else if (flush) begin
        w_act = 0;
        w_drain = 1;
      end
    end else if (w_drain) begin
      if (mem_rsp_valid) w_drain = 0;
    end else if (!flush) begin
      for (int k = 1; k <= THREADS; k++) begin
        t = (m_last + k) % THREADS;
        if (m_pend[t]) begin
          w_act = 1; w_sent = 0; w_got = 0;
          w_tid = t; w_va = m_va[t];
          break;
        end
      end
    end
    if (flush) begin
      for (int k = 0; k < THREADS; k++) m_pend[k] = 0;
    end else if (miss_valid && !m_pend[miss_thread_id]) begin
      m_pend[miss_thread_id] = 1;
      m_va[miss_thread_id] = miss_virt_addr;
    end
  endtask

  task automatic adv();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic do_miss(input int t, input logic [31:0] v);
    miss_valid = 1'b1;
    miss_thread_id = TID_W'(t);
    miss_virt_addr = v;
  endtask

  // Quiet inputs; memory accepts at once and answers the first cycle it may.
  task automatic auto_mem();
    reset = 1'b0; flush = 1'b0; miss_valid = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = awaiting_rsp() || w_drain;
    mem_rsp_data = 32'h000A_B001;
  endtask

  task automatic run_auto(input int n);
    for (int i = 0; i < n; i++) begin
      auto_mem();
      cmp();
      adv();
    end
  endtask

  initial begin
    int          npulse, pulses;
    bit          chk_next, re3, re0, seen;
    int          exp_order[5];
    logic [31:0] tmp;

    reset = 1'b1; flush = 1'b0; miss_valid = 1'b0;
    miss_thread_id = '0; miss_virt_addr = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    ptbr = 20'h10000;
    @(negedge clock);
    adv();
    reset = 1'b0;

    // Reset state
    cmp();
    check("rst_pending", pending, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_refill", new_tlb_entry, 0);
    check("rst_fault", page_fault, 0);
    adv();

    // Basic refill and page fault: thread 1, VA 0x3ABC, ptbr 0x10000
    for (int pass = 0; pass < 2; pass++) begin
      auto_mem(); do_miss(1, 32'h0000_3ABC);
      cmp(); adv();
      miss_valid = 1'b0;
      cmp(); check("lit_pending_set", pending, 4'b0010); adv();
      cmp();
      check("lit_req_valid", mem_req_valid, 1);
      check("lit_req_addr", mem_req_addr, 20'h1000C);
      adv();
      mem_rsp_valid = 1'b1;
      mem_rsp_data = (pass == 0) ? 32'h0004_5001 : 32'h0004_5000;
      cmp(); adv();
      mem_rsp_valid = 1'b0;
      cmp();
      if (pass == 0) begin
        check("lit_refill", new_tlb_entry, 1);
        check("lit_refill_tid", new_tlb_thread_id, 1);
        check("lit_refill_info", new_tlb_info, {32'h0000_3ABC, 20'h45ABC});
      end else begin
        check("lit_fault", page_fault, 1);
        check("lit_fault_tid", page_fault_thread_id, 1);
        check("lit_fault_addr", page_fault_addr, 32'h0000_3ABC);
        check("lit_fault_no_refill", new_tlb_entry, 0);
      end
      adv();
      cmp(); check("lit_pending_clear", pending, 0); adv();
    end

    // Round-robin: thread 3 walks first, with ready held low for 5 cycles.
    // Threads 2 and 0 queue up meanwhile, and thread 3 misses again in its
    // own FILL cycle. Thread 0 misses again in its FILL cycle.
    auto_mem(); reset = 1'b1; cmp(); adv(); reset = 1'b0;
    order_q.delete();
    chk_next = 0; re3 = 0; re0 = 0;
    for (int c = 0; c < 80 && order_q.size() < 5; c++) begin
      auto_mem();
      mem_req_ready = !(c >= 2 && c <= 6);
      if (c == 0) do_miss(3, 32'h0000_5123);
      if (c == 3) do_miss(2, 32'h0000_7456);
      if (c == 4) do_miss(0, 32'h0001_1789);
      if (w_act && w_got && w_tid == 3 && !re3) begin
        do_miss(3, 32'h0002_2222); re3 = 1;
      end
      if (w_act && w_got && w_tid == 0 && !re0) begin
        do_miss(0, 32'h0003_3333); re0 = 1;
      end
      cmp();
      if (c >= 2 && c <= 7) begin
        check("rr_req_held", mem_req_valid, 1);
        check("rr_addr_stable", mem_req_addr, 20'h10014);
      end
      if (chk_next) begin
        check("coincident_pend3", pending[3], 1);
        chk_next = 0;
      end
      if (miss_valid && miss_thread_id == 2'd3 && re3 && c > 0 && !chk_next) chk_next = (miss_virt_addr == 32'h0002_2222);
      adv();
    end
    exp_order = '{3, 0, 2, 3, 0};
    check("rr_count", order_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < order_q.size()) check("rr_order", order_q[i], exp_order[i]);

    // Duplicate miss ignored. A miss in the thread's own FILL cycle is kept.
    run_auto(6);
    npulse = 0; chk_next = 0;
    for (int c = 0; c < 40 && npulse < 2; c++) begin
      auto_mem();
      if (c == 0) do_miss(2, 32'h0000_9AAA);
      if (c == 1) do_miss(2, 32'h0000_CBBB);
      if (w_act && w_got && w_tid == 2 && npulse == 0) begin
        do_miss(2, 32'h0000_DCCC); chk_next = 1;
      end
      cmp();
      if (new_tlb_entry === 1'b1) begin
        npulse++;
        check(npulse == 1 ? "dup_keeps_first" : "fill_cycle_new_va",
              new_tlb_info[51:20], npulse == 1 ? 32'h0000_9AAA : 32'h0000_DCCC);
      end
      adv();
      if (chk_next && npulse == 1) begin
        auto_mem(); cmp();
        check("fill_cycle_pend2", pending[2], 1);
        chk_next = 0;
        adv();
      end
    end
    check("dup_pulses", npulse, 2);

    // Flush one cycle after the handshake; the response comes 3 cycles later.
    run_auto(6);
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      auto_mem(); mem_rsp_valid = 1'b0;
      if (c == 0) do_miss(1, 32'h0000_4321);
      if (c == 3) flush = 1'b1;
      if (c == 6) begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0005_5001; end
      cmp();
      if (new_tlb_entry === 1'b1 || page_fault === 1'b1) pulses++;
      if (c == 2) check("flush_pre_req", mem_req_valid, 1);
      if (c >= 4) check("flush_no_req", mem_req_valid, 0);
      if (c == 7) check("flush_pending", pending, 0);
      adv();
    end
    check("flush_no_pulse", pulses, 0);

    // Reset in WAIT, then a normal walk.
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      auto_mem();
      if (c == 0) do_miss(2, 32'h0000_8123);
      if (c == 3) begin reset = 1'b1; mem_rsp_valid = 1'b0; end
      if (c == 5) do_miss(1, 32'h0000_6ABC);
      cmp();
      if (c == 4) begin
        check("rstw_pending", pending, 0);
        check("rstw_req_valid", mem_req_valid, 0);
        check("rstw_req_addr", mem_req_addr, 0);
        check("rstw_refill", new_tlb_entry, 0);
        check("rstw_info", new_tlb_info, 0);
        check("rstw_fault", page_fault, 0);
      end
      if (new_tlb_entry === 1'b1) begin
        seen = 1;
        check("post_reset_tid", new_tlb_thread_id, 1);
        check("post_reset_info", new_tlb_info, {32'h0000_6ABC, 20'hABABC});
      end
      adv();
    end
    check("post_reset_refill", seen, 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 29) == 0);
      miss_valid = ($urandom_range(0, 2) == 0);
      miss_thread_id = TID_W'($urandom_range(0, THREADS - 1));
      miss_virt_addr = $urandom;
      mem_req_ready = ($urandom_range(0, 2) != 0);
      mem_rsp_valid = (awaiting_rsp() || w_drain) && ($urandom_range(0, 1) == 1);
      tmp = $urandom;
      tmp[0] = ($urandom_range(0, 3) != 0);
      mem_rsp_data = tmp;
      if ($urandom_range(0, 99) == 0) ptbr = PADDR_W'($urandom);
      cmp();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
